// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
    } cls_e;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [1:0] WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2;
    localparam logic [1:0] PC_PLUS4 = 2'd0, PC_TARGET = 2'd1, PC_JALR = 2'd2;
    localparam logic [1:0] FAULT_NONE = 2'd0, FAULT_ILLEGAL = 2'd1, FAULT_IMEM = 2'd2, FAULT_DMEM = 2'd3;
endpackage

// File: rtl/opcode_class.sv
// opcode_class: combinational RV32I opcode classifier with illegal-opcode flag.
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_e       cls,
    output logic       illegal
);
    always_comb begin
        cls = CLS_R;
        illegal = 1'b0;
        case (opcode)
            OP_R:     cls = CLS_R;
            OP_I:     cls = CLS_I;
            OP_LOAD:  cls = CLS_LOAD;
            OP_STORE: cls = CLS_STORE;
            OP_BR:    cls = CLS_BR;
            OP_JAL:   cls = CLS_JAL;
            OP_JALR:  cls = CLS_JALR;
            OP_LUI:   cls = CLS_LUI;
            OP_AUIPC: cls = CLS_AUIPC;
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for the multi-cycle RV32I core.
// Strobes decode from the state register; ready-driven strobes are Mealy.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_a_pc,
    output logic             alu_b_imm,
    output logic [1:0]       wb_sel,
    output logic             regwrite,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);
    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, dec_cls;
    logic             dec_illegal, retire, timeout;
    logic [15:0]      wait_q, wait_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    opcode_class u_cls (.opcode(opcode), .cls(dec_cls), .illegal(dec_illegal));

    // ready arriving in the WAIT_MAX-th waiting cycle still wins
    assign timeout = wait_q == 16'(WAIT_MAX - 1);
    assign fault   = fault_q;
    assign instret = instret_q;

    always_comb begin
        state_d = state_q;
        cls_d = cls_q;
        fault_d = fault_q;
        retire = 1'b0;
        imem_req = 1'b0;
        ir_load = 1'b0;
        dmem_req = 1'b0;
        dmem_we = 1'b0;
        alu_a_pc = 1'b0;
        alu_b_imm = 1'b0;
        wb_sel = WB_ALU;
        regwrite = 1'b0;
        pc_en = 1'b0;
        pc_sel = PC_PLUS4;
        case (state_q)
            S_FETCH: begin
                imem_req = rst_n;
                ir_load = rst_n & imem_ready;
                state_d = imem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
                fault_d = (!imem_ready && timeout) ? FAULT_IMEM : fault_q;
            end
            S_DECODE: begin
                cls_d = dec_cls;
                state_d = dec_illegal ? S_TRAP : S_EXEC;
                fault_d = dec_illegal ? FAULT_ILLEGAL : fault_q;
            end
            S_EXEC: begin
                alu_a_pc = cls_q inside {CLS_BR, CLS_JAL, CLS_AUIPC};
                alu_b_imm = cls_q != CLS_R;
                pc_en = cls_q == CLS_BR;
                pc_sel = (cls_q == CLS_BR && branch_taken) ? PC_TARGET : PC_PLUS4;
                retire = cls_q == CLS_BR;
                state_d = (cls_q inside {CLS_LOAD, CLS_STORE}) ? S_MEM : cls_q == CLS_BR ? S_FETCH : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we = cls_q == CLS_STORE;
                pc_en = dmem_we & dmem_ready;
                retire = dmem_we & dmem_ready;
                state_d = dmem_ready ? (dmem_we ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
                fault_d = (!dmem_ready && timeout) ? FAULT_DMEM : fault_q;
            end
            S_WB: begin
                regwrite = rd != 5'd0;
                wb_sel = cls_q == CLS_LOAD ? WB_LOAD : (cls_q inside {CLS_JAL, CLS_JALR}) ? WB_PC4 : WB_ALU;
                pc_en = 1'b1;
                pc_sel = cls_q == CLS_JAL ? PC_TARGET : cls_q == CLS_JALR ? PC_JALR : PC_PLUS4;
                retire = 1'b1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
        instret_d = instret_q + CNT_W'(retire);
        wait_d = (state_d == state_q && state_q != S_TRAP) ? wait_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q <= CLS_R;
            wait_q <= '0;
            fault_q <= FAULT_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q <= cls_d;
            wait_q <= wait_d;
            fault_q <= fault_d;
            instret_q <= instret_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed table-driven bench for the multi-cycle control FSM.
module tb_multicycle_ctrl;
    localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011, BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, ADD = 7'b0110011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, BAD = 7'h7F;
    // {imem_req,ir_load,dmem_req,dmem_we}_{alu_a_pc,alu_b_imm}_wb_sel_{regwrite,pc_en}_pc_sel_fault
    localparam logic [13:0] O_NONE  = 14'b0000_00_00_00_00_00;
    localparam logic [13:0] O_FETCH = 14'b1100_00_00_00_00_00;
    localparam logic [13:0] O_FWAIT = 14'b1000_00_00_00_00_00;
    localparam logic [13:0] O_EXI   = 14'b0000_01_00_00_00_00;
    localparam logic [13:0] O_EXPC  = 14'b0000_11_00_00_00_00;
    localparam logic [13:0] O_MEMRD = 14'b0010_00_00_00_00_00;
    localparam logic [13:0] O_WBALU = 14'b0000_00_00_11_00_00;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        bt, ir, dr;
        logic [13:0] o;
        int          ret;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [4:0] rd = '0;
    logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, ir_load, dmem_req, dmem_we, alu_a_pc, alu_b_imm, regwrite, pc_en;
    logic [1:0] wb_sel, pc_sel, fault;
    logic [31:0] instret;
    logic [13:0] o;
    int n_chk = 0, n_fail = 0;
    vec_t tbl[$];

    multicycle_ctrl #(.WAIT_MAX(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd(rd), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm),
        .wb_sel(wb_sel), .regwrite(regwrite), .pc_en(pc_en), .pc_sel(pc_sel), .fault(fault),
        .instret(instret)
    );

    assign o = {imem_req, ir_load, dmem_req, dmem_we, alu_a_pc, alu_b_imm, wb_sel, regwrite, pc_en, pc_sel, fault};

    always #5 clk = ~clk;

    function automatic vec_t v(logic [6:0] op, logic [4:0] r, logic bt, logic ir, logic dr, logic [13:0] eo, int ret);
        vec_t x;
        x.op = op; x.rd = r; x.bt = bt; x.ir = ir; x.dr = dr; x.o = eo; x.ret = ret;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] r, input logic bt, input logic ir, input logic dr);
        opcode = op; rd = r; branch_taken = bt; imem_ready = ir; dmem_ready = dr;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        opcode = '0; rd = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_mem(input logic [6:0] op);
        set_in(op, 5'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(op, 5'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(op, 5'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        tbl.push_back(v(ADDI, 1, 0, 1, 0, O_FETCH, 0));
        tbl.push_back(v(ADDI, 1, 0, 0, 0, O_NONE, 0));
        tbl.push_back(v(ADDI, 1, 0, 0, 0, O_EXI, 0));
        tbl.push_back(v(ADDI, 1, 0, 0, 0, O_WBALU, 0));
        tbl.push_back(v(LW, 2, 0, 1, 0, O_FETCH, 1));
        tbl.push_back(v(LW, 2, 0, 0, 0, O_NONE, 1));
        tbl.push_back(v(LW, 2, 0, 0, 0, O_EXI, 1));
        tbl.push_back(v(LW, 2, 0, 0, 0, O_MEMRD, 1));
        tbl.push_back(v(LW, 2, 0, 0, 0, O_MEMRD, 1));
        tbl.push_back(v(LW, 2, 0, 0, 0, O_MEMRD, 1));
        tbl.push_back(v(LW, 2, 0, 0, 1, O_MEMRD, 1));
        tbl.push_back(v(LW, 2, 0, 0, 0, 14'b0000_00_01_11_00_00, 1));
        tbl.push_back(v(BEQ, 0, 1, 0, 0, O_FWAIT, 2));
        tbl.push_back(v(BEQ, 0, 1, 1, 0, O_FETCH, 2));
        tbl.push_back(v(BEQ, 0, 1, 0, 0, O_NONE, 2));
        tbl.push_back(v(BEQ, 0, 1, 0, 0, 14'b0000_11_00_01_01_00, 2));
        tbl.push_back(v(ADDI, 0, 0, 1, 1, O_FETCH, 3));
        tbl.push_back(v(ADDI, 0, 0, 0, 0, O_NONE, 3));
        tbl.push_back(v(ADDI, 0, 0, 0, 0, O_EXI, 3));
        tbl.push_back(v(ADDI, 0, 0, 0, 0, 14'b0000_00_00_01_00_00, 3));
        tbl.push_back(v(JAL, 1, 0, 1, 0, O_FETCH, 4));
        tbl.push_back(v(JAL, 1, 0, 0, 0, O_NONE, 4));
        tbl.push_back(v(JAL, 1, 0, 0, 0, O_EXPC, 4));
        tbl.push_back(v(JAL, 1, 0, 0, 0, 14'b0000_00_10_11_01_00, 4));
        tbl.push_back(v(JALR, 1, 0, 1, 0, O_FETCH, 5));
        tbl.push_back(v(JALR, 1, 0, 0, 0, O_NONE, 5));
        tbl.push_back(v(JALR, 1, 0, 0, 0, O_EXI, 5));
        tbl.push_back(v(JALR, 1, 0, 0, 0, 14'b0000_00_10_11_10_00, 5));
        tbl.push_back(v(SW, 3, 0, 1, 0, O_FETCH, 6));
        tbl.push_back(v(SW, 3, 0, 0, 0, O_NONE, 6));
        tbl.push_back(v(SW, 3, 0, 0, 0, O_EXI, 6));
        tbl.push_back(v(SW, 3, 0, 0, 1, 14'b0011_00_00_01_00_00, 6));
        tbl.push_back(v(BEQ, 0, 0, 1, 0, O_FETCH, 7));
        tbl.push_back(v(BEQ, 0, 0, 0, 0, O_NONE, 7));
        tbl.push_back(v(BEQ, 0, 0, 1, 1, 14'b0000_11_00_01_00_00, 7));
        tbl.push_back(v(ADD, 5, 0, 1, 0, O_FETCH, 8));
        tbl.push_back(v(ADD, 5, 0, 0, 0, O_NONE, 8));
        tbl.push_back(v(ADD, 5, 0, 0, 0, O_NONE, 8));
        tbl.push_back(v(ADD, 5, 0, 0, 0, O_WBALU, 8));
        tbl.push_back(v(LUI, 4, 0, 1, 0, O_FETCH, 9));
        tbl.push_back(v(LUI, 4, 0, 0, 0, O_NONE, 9));
        tbl.push_back(v(LUI, 4, 0, 0, 0, O_EXI, 9));
        tbl.push_back(v(LUI, 4, 0, 0, 0, O_WBALU, 9));
        tbl.push_back(v(AUIPC, 4, 0, 1, 0, O_FETCH, 10));
        tbl.push_back(v(AUIPC, 4, 0, 0, 0, O_NONE, 10));
        tbl.push_back(v(AUIPC, 4, 0, 0, 0, O_EXPC, 10));
        tbl.push_back(v(AUIPC, 4, 0, 0, 0, O_WBALU, 10));
        tbl.push_back(v(ADDI, 1, 0, 0, 0, O_FWAIT, 11));

        // reset state: every strobe low while rst_n is asserted
        #1;
        chk("reset outputs", 32'(o), 32'(O_NONE));
        chk("reset instret", instret, 32'd0);
        do_reset();
        foreach (tbl[i]) begin
            set_in(tbl[i].op, tbl[i].rd, tbl[i].bt, tbl[i].ir, tbl[i].dr);
            chk($sformatf("vec%0d outputs", i), 32'(o), 32'(tbl[i].o));
            chk($sformatf("vec%0d instret", i), instret, 32'(tbl[i].ret));
            @(negedge clk);
        end

        // illegal opcode traps and never fetches again
        do_reset();
        set_in(BAD, 0, 0, 1, 0);
        chk("illegal ir_load", 32'(ir_load), 32'd1);
        @(negedge clk);
        set_in(BAD, 0, 0, 1, 0);
        chk("illegal decode outputs", 32'(o), 32'(O_NONE));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            set_in(ADDI, 1, 0, 1, 1);
            chk($sformatf("trap%0d outputs", k), 32'(o), 32'(14'b0000_00_00_00_00_01));
            chk($sformatf("trap%0d instret", k), instret, 32'd0);
            @(negedge clk);
        end

        // imem timeout after exactly 8 waiting cycles
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            set_in(ADDI, 1, 0, 0, 0);
            if (k == 8) chk("imem wait8 outputs", 32'(o), 32'(O_FWAIT));
            @(negedge clk);
        end
        set_in(ADDI, 1, 0, 1, 0);
        chk("imem timeout outputs", 32'(o), 32'(14'b0000_00_00_00_00_10));

        // ready in the 8th waiting cycle beats the timeout
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            set_in(ADDI, 1, 0, 0, 0);
            @(negedge clk);
        end
        set_in(ADDI, 1, 0, 1, 0);
        chk("imem late ready outputs", 32'(o), 32'(O_FETCH));
        @(negedge clk);
        set_in(ADDI, 1, 0, 0, 0);
        chk("imem late decode outputs", 32'(o), 32'(O_NONE));
        @(negedge clk);
        set_in(ADDI, 1, 0, 0, 0);
        chk("imem late exec outputs", 32'(o), 32'(O_EXI));

        // dmem timeout on a load
        do_reset();
        run_to_mem(LW);
        for (int k = 1; k <= 8; k++) begin
            set_in(LW, 2, 0, 0, 0);
            if (k == 8) chk("dmem wait8 outputs", 32'(o), 32'(O_MEMRD));
            @(negedge clk);
        end
        set_in(LW, 2, 0, 0, 1);
        chk("dmem timeout outputs", 32'(o), 32'(14'b0000_00_00_00_00_11));

        // async reset in MEM drops dmem_req and clears instret at once
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(ADDI, 1, 0, k == 0, 0);
            @(negedge clk);
        end
        run_to_mem(LW);
        set_in(LW, 2, 0, 0, 0);
        chk("pre-reset mem outputs", 32'(o), 32'(O_MEMRD));
        chk("pre-reset instret", instret, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-reset outputs", 32'(o), 32'(O_NONE));
        chk("mid-reset instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(LW, 2, 0, 0, 1);
        chk("post-reset fetch outputs", 32'(o), 32'(O_FWAIT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
